// File: rtl/tag_array_nway.sv
// N-way set-associative tag store: valid/dirty per line, fill/inv/mark port, flush sweeper.
// Define TAG_ARRAY_DIRTY_EN to build dirty bits (required by write-back caches).
module tag_array_nway #(
   parameter int unsigned TAG_W   = 4,
   parameter int unsigned INDEX_W = 4,
   parameter int unsigned WAYS    = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [TAG_W-1:0]         i_lk_tag,
   input  logic [INDEX_W-1:0]       i_lk_index,
   output logic [WAYS-1:0]          o_hit_en,
   output logic                     o_hit,
   output logic [$clog2(WAYS)-1:0]  o_hit_way,
   input  logic                     i_fill_en,
   input  logic [INDEX_W-1:0]       i_fill_index,
   input  logic [$clog2(WAYS)-1:0]  i_fill_way,
   input  logic [TAG_W-1:0]         i_fill_tag,
   output logic                     o_vic_valid,
   output logic [TAG_W-1:0]         o_vic_tag,
   output logic                     o_vic_dirty,
   input  logic                     i_mark_en,
   input  logic                     i_inv_en,
   input  logic                     i_flush_req,
   output logic                     o_flush_busy,
   output logic                     o_flush_done
);

   localparam int unsigned LINES = 1 << INDEX_W;
   localparam int unsigned WAY_W = $clog2(WAYS);

   typedef enum logic [1:0] {StIdle, StSweep, StDone} state_e;

   state_e               r_state, w_state_next;
   logic [INDEX_W-1:0]   r_ptr, w_ptr_next;
   logic                 w_idle, w_sweep;

   logic [TAG_W-1:0]     r_tag   [WAYS][LINES];
   logic [LINES-1:0]     r_valid [WAYS];
   logic [LINES-1:0]     w_clr   [WAYS];
   logic [LINES-1:0]     w_fill  [WAYS];

   assign w_idle       = (r_state == StIdle);
   assign w_sweep      = (r_state == StSweep);
   assign o_flush_busy = w_sweep;
   assign o_flush_done = (r_state == StDone);

   // Flush sequencer; termination is by compare against the last set.
   always_comb begin
      w_state_next = r_state;
      w_ptr_next   = r_ptr;
      case (r_state)
         StIdle: begin
            if (i_flush_req) begin
               w_state_next = StSweep;
               w_ptr_next   = '0;
            end
         end
         StSweep: begin
            w_ptr_next = r_ptr + INDEX_W'(1);
            if (r_ptr == INDEX_W'(LINES - 1)) w_state_next = StDone;
         end
         StDone:  w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
         r_ptr   <= '0;
      end else begin
         r_state <= w_state_next;
         r_ptr   <= w_ptr_next;
      end
   end

   // Per-line write strobes; clear (sweep or inv) beats fill on the same line.
   always_comb begin
      for (int w = 0; w < WAYS; w++) begin
         w_clr[w]  = '0;
         w_fill[w] = '0;
         for (int l = 0; l < LINES; l++) begin
            w_clr[w][l]  = (w_sweep && r_ptr == INDEX_W'(l)) ||
                           (w_idle && i_inv_en && i_fill_index == INDEX_W'(l) &&
                            i_fill_way == WAY_W'(w));
            w_fill[w][l] = w_idle && i_fill_en && !i_inv_en &&
                           i_fill_index == INDEX_W'(l) && i_fill_way == WAY_W'(w);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int w = 0; w < WAYS; w++) begin
            r_valid[w] <= '0;
            for (int l = 0; l < LINES; l++) r_tag[w][l] <= '0;
         end
      end else begin
         for (int w = 0; w < WAYS; w++) begin
            for (int l = 0; l < LINES; l++) begin
               if (w_clr[w][l]) begin
                  r_valid[w][l] <= 1'b0;
               end else if (w_fill[w][l]) begin
                  r_valid[w][l] <= 1'b1;
                  r_tag[w][l]   <= i_fill_tag;
               end
            end
         end
      end
   end

`ifdef TAG_ARRAY_DIRTY_EN
   logic [LINES-1:0] r_dirty [WAYS];
   logic [LINES-1:0] w_mark  [WAYS];

   // Mark loses to any inv/fill aimed at the same line.
   always_comb begin
      for (int w = 0; w < WAYS; w++) begin
         w_mark[w] = '0;
         for (int l = 0; l < LINES; l++) begin
            w_mark[w][l] = w_idle && i_mark_en && o_hit &&
                           i_lk_index == INDEX_W'(l) && o_hit_way == WAY_W'(w) &&
                           !((i_inv_en || i_fill_en) && i_fill_index == INDEX_W'(l) &&
                             i_fill_way == WAY_W'(w));
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int w = 0; w < WAYS; w++) r_dirty[w] <= '0;
      end else begin
         for (int w = 0; w < WAYS; w++) begin
            for (int l = 0; l < LINES; l++) begin
               if (w_clr[w][l] || w_fill[w][l]) r_dirty[w][l] <= 1'b0;
               else if (w_mark[w][l])           r_dirty[w][l] <= 1'b1;
            end
         end
      end
   end

   assign o_vic_dirty = r_dirty[i_fill_way][i_fill_index];
`else
   logic w_unused_mark;
   assign w_unused_mark = i_mark_en;
   assign o_vic_dirty   = 1'b0;
`endif

   assign o_vic_valid = r_valid[i_fill_way][i_fill_index];
   assign o_vic_tag   = r_tag[i_fill_way][i_fill_index];

   always_comb begin
      o_hit_en = '0;
      for (int w = 0; w < WAYS; w++) begin
         o_hit_en[w] = !w_sweep && r_valid[w][i_lk_index] &&
                       (r_tag[w][i_lk_index] == i_lk_tag);
      end
   end

   assign o_hit = |o_hit_en;

   // Descending scan so the lowest set way is the last to be written.
   always_comb begin
      o_hit_way = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (o_hit_en[w]) o_hit_way = WAY_W'(w);
      end
   end

endmodule

// File: tb/tb_tag_array_nway.sv
// Directed scoreboard bench for tag_array_nway at default parameters (4 tag, 16 sets, 4 ways).
module tb_tag_array_nway;

`ifdef TAG_ARRAY_DIRTY_EN
   localparam logic DIRTY = 1'b1;
`else
   localparam logic DIRTY = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] lk_tag, fill_tag;
   logic [3:0] lk_index, fill_index;
   logic [1:0] fill_way;
   logic       fill_en, mark_en, inv_en, flush_req;
   logic [3:0] hit_en;
   logic       hit;
   logic [1:0] hit_way;
   logic       vic_valid, vic_dirty, flush_busy, flush_done;
   logic [3:0] vic_tag;

   always #5 clk = ~clk;

   tag_array_nway dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_lk_tag     (lk_tag),
      .i_lk_index   (lk_index),
      .o_hit_en     (hit_en),
      .o_hit        (hit),
      .o_hit_way    (hit_way),
      .i_fill_en    (fill_en),
      .i_fill_index (fill_index),
      .i_fill_way   (fill_way),
      .i_fill_tag   (fill_tag),
      .o_vic_valid  (vic_valid),
      .o_vic_tag    (vic_tag),
      .o_vic_dirty  (vic_dirty),
      .i_mark_en    (mark_en),
      .i_inv_en     (inv_en),
      .i_flush_req  (flush_req),
      .o_flush_busy (flush_busy),
      .o_flush_done (flush_done)
   );

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   task automatic expect_val(input string tag, input logic [31:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      sb.push_back(e);
   endtask

   task automatic check_next(input logic [31:0] obs);
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $error("FAIL scoreboard_empty: observed=%0h expected=none", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill(input logic [3:0] idx, input logic [1:0] way, input logic [3:0] tag);
      fill_en = 1'b1; fill_index = idx; fill_way = way; fill_tag = tag;
      tick();
      fill_en = 1'b0;
   endtask

   // Walks every (set, way) through the victim port and counts valid lines.
   task automatic count_valid(output int n);
      n = 0;
      for (int s = 0; s < 16; s++) begin
         for (int w = 0; w < 4; w++) begin
            fill_index = 4'(s);
            fill_way   = 2'(w);
            #1;
            if (vic_valid === 1'b1) n++;
         end
      end
   endtask

   initial begin
      int n_valid, busy_cnt, i;
      logic hit_seen, done_seen;

      rst_n = 1'b0; lk_tag = '0; lk_index = '0; fill_en = 1'b0; fill_index = '0;
      fill_way = '0; fill_tag = '0; mark_en = 1'b0; inv_en = 1'b0; flush_req = 1'b0;
      tick(); tick();
      rst_n = 1'b1;

      // Reset state
      lk_index = 4'd3; lk_tag = 4'h0;
      expect_val("rst_hit_en", 4'b0000);
      expect_val("rst_hit", 0);
      expect_val("rst_hit_way", 0);
      expect_val("rst_busy", 0);
      expect_val("rst_done", 0);
      expect_val("rst_vic_valid", 0);
      expect_val("rst_vic_dirty", 0);
      #1;
      check_next(32'(hit_en)); check_next(32'(hit)); check_next(32'(hit_way));
      check_next(32'(flush_busy)); check_next(32'(flush_done));
      check_next(32'(vic_valid)); check_next(32'(vic_dirty));

      // Fill with same-cycle lookup: no bypass
      fill_en = 1'b1; fill_index = 4'd5; fill_way = 2'd2; fill_tag = 4'hA;
      lk_index = 4'd5; lk_tag = 4'hA;
      expect_val("fill_same_cycle_hit", 0);
      expect_val("fill_same_cycle_vic_valid", 0);
      #1;
      check_next(32'(hit)); check_next(32'(vic_valid));
      tick();
      fill_en = 1'b0;
      expect_val("fill_hit_en", 4'b0100);
      expect_val("fill_hit", 1);
      expect_val("fill_hit_way", 2);
      #1;
      check_next(32'(hit_en)); check_next(32'(hit)); check_next(32'(hit_way));
      lk_tag = 4'hB;
      expect_val("miss_other_tag", 0);
      #1;
      check_next(32'(hit));

      // Mark dirty via hit, then read victim info
      lk_tag = 4'hA; mark_en = 1'b1;
      tick();
      mark_en = 1'b0;
      expect_val("vic_valid_after_mark", 1);
      expect_val("vic_tag_after_mark", 4'hA);
      expect_val("vic_dirty_after_mark", 32'(DIRTY));
      #1;
      check_next(32'(vic_valid)); check_next(32'(vic_tag)); check_next(32'(vic_dirty));

      // Refill clears dirty; pre-write victim still dirty in fill cycle
      fill_en = 1'b1; fill_index = 4'd5; fill_way = 2'd2; fill_tag = 4'hC;
      expect_val("refill_pre_vic_dirty", 32'(DIRTY));
      #1;
      check_next(32'(vic_dirty));
      tick();
      fill_en = 1'b0;
      expect_val("refill_vic_dirty", 0);
      expect_val("refill_vic_tag", 4'hC);
      #1;
      check_next(32'(vic_dirty)); check_next(32'(vic_tag));

      // Two ways share a tag: lowest way wins encoding
      fill(4'd4, 2'd3, 4'h7);
      fill(4'd4, 2'd1, 4'h7);
      lk_index = 4'd4; lk_tag = 4'h7;
      expect_val("multi_hit_en", 4'b1010);
      expect_val("multi_hit_way", 1);
      #1;
      check_next(32'(hit_en)); check_next(32'(hit_way));

      // inv and fill on the same line: inv wins
      fill(4'd9, 2'd1, 4'h3);
      inv_en = 1'b1;
      fill(4'd9, 2'd1, 4'h6);
      inv_en = 1'b0;
      expect_val("inv_fill_same_valid", 0);
      #1;
      check_next(32'(vic_valid));
      lk_index = 4'd9; lk_tag = 4'h6;
      expect_val("inv_fill_same_hit", 0);
      #1;
      check_next(32'(hit));

      // inv on (9,1) in parallel with mark on (9,0)
      fill(4'd9, 2'd0, 4'h2);
      fill(4'd9, 2'd1, 4'h4);
      lk_index = 4'd9; lk_tag = 4'h2; mark_en = 1'b1;
      inv_en = 1'b1; fill_index = 4'd9; fill_way = 2'd1;
      tick();
      inv_en = 1'b0; mark_en = 1'b0;
      expect_val("par_inv_valid", 0);
      #1;
      check_next(32'(vic_valid));
      fill_way = 2'd0;
      expect_val("par_mark_valid", 1);
      expect_val("par_mark_dirty", 32'(DIRTY));
      #1;
      check_next(32'(vic_valid)); check_next(32'(vic_dirty));

      // fill and mark on the same line: fill wins, dirty cleared
      mark_en = 1'b1;
      fill(4'd9, 2'd0, 4'h2);
      mark_en = 1'b0;
      expect_val("fill_mark_same_dirty", 0);
      #1;
      check_next(32'(vic_dirty));

      // Flush sweep
      for (int s = 0; s < 3; s++) begin
         for (int w = 0; w < 4; w++) begin
            fill((s == 0) ? 4'd0 : (s == 1) ? 4'd7 : 4'd15, 2'(w), 4'(w + 8));
         end
      end
      lk_index = 4'd7; lk_tag = 4'h9;
      expect_val("pre_flush_hit", 1);
      #1;
      check_next(32'(hit));
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      busy_cnt = 0; hit_seen = 1'b0; done_seen = 1'b0; i = 0;
      while (flush_busy === 1'b1 && i < 40) begin
         busy_cnt++;
         hit_seen  = hit_seen | hit;
         done_seen = done_seen | flush_done;
         // Fill into set 1 while the pointer is already past it
         fill_en = (busy_cnt == 5); fill_index = 4'd1; fill_way = 2'd0; fill_tag = 4'h5;
         tick();
         i++;
      end
      fill_en = 1'b0;
      expect_val("flush_busy_cycles", 16);
      expect_val("flush_hit_during_sweep", 0);
      expect_val("flush_done_during_sweep", 0);
      expect_val("flush_done_pulse", 1);
      check_next(32'(busy_cnt)); check_next(32'(hit_seen)); check_next(32'(done_seen));
      check_next(32'(flush_done));
      tick();
      expect_val("flush_done_one_cycle", 0);
      expect_val("flush_idle_busy", 0);
      check_next(32'(flush_done)); check_next(32'(flush_busy));
      count_valid(n_valid);
      expect_val("flush_all_invalid", 0);
      check_next(32'(n_valid));

      // Reset mid-sweep at sweep cycle 6
      fill(4'd12, 2'd3, 4'hE);
      fill(4'd2, 2'd0, 4'h1);
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      expect_val("midsweep_busy_before_rst", 1);
      check_next(32'(flush_busy));
      rst_n = 1'b0;
      #1;
      expect_val("rst_abort_busy", 0);
      expect_val("rst_abort_done", 0);
      check_next(32'(flush_busy)); check_next(32'(flush_done));
      #2;
      rst_n = 1'b1;
      count_valid(n_valid);
      expect_val("rst_abort_all_invalid", 0);
      check_next(32'(n_valid));
      tick();
      expect_val("rst_abort_stays_idle", 0);
      check_next(32'(flush_busy));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global time bound so the bench always ends
   initial begin
      #200000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
